// File: rtl/pll_reset_sequencer.sv
// Supervises the rPLL reset and lock, then releases downstream resets in stages.
// On lock loss, relock request or timeout, it re-sequences; after too many retries it holds in FAIL.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned LOCK_TIMEOUT   = 270000,
  parameter int unsigned LOSS_FILTER    = 4,
  parameter int unsigned STAGE_GAP      = 64,
  parameter int unsigned NUM_STAGES     = 3,
  parameter int unsigned MAX_RETRIES    = 7,
  parameter int unsigned CNT_W          = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_lock,
  input  logic                  relock_req,
  output logic                  pll_reset,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  locked_ok,
  output logic                  fault,
  output logic [3:0]            retry_cnt,
  output logic [7:0]            loss_cnt,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_e;

  localparam int unsigned STB_W = $clog2(LOCK_STABLE + 1);
  localparam int unsigned LSS_W = $clog2(LOSS_FILTER + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(STAGE_GAP * NUM_STAGES - 1);
  localparam logic [STB_W-1:0] STABLE_LAST  = STB_W'(LOCK_STABLE - 1);
  localparam logic [LSS_W-1:0] LOSS_LAST    = LSS_W'(LOSS_FILTER - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      timer_q, timer_d;
  logic [STB_W-1:0]      stable_q, stable_d;
  logic [LSS_W-1:0]      filter_q, filter_d;
  logic [3:0]            retry_q, retry_d;
  logic [7:0]            loss_q, loss_d;
  logic                  lock_meta_q, lock_s_q;
  logic                  pll_reset_q, pll_reset_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  locked_q, locked_d;
  logic                  fault_q, fault_d;

  logic in_release_run, qualify, timeout, loss_det;

  // Process 1: all state, including the two-flop lock synchroniser.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET_PLL;
      timer_q     <= '0;
      stable_q    <= '0;
      filter_q    <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_reset_q <= 1'b1;
      stage_q     <= '0;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      stable_q    <= stable_d;
      filter_q    <= filter_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
      pll_reset_q <= pll_reset_d;
      stage_q     <= stage_d;
      locked_q    <= locked_d;
      fault_q     <= fault_d;
    end
  end

  assign in_release_run = (state_q == S_RELEASE) || (state_q == S_RUN);
  assign qualify  = (state_q == S_WAIT_LOCK) && lock_s_q && (stable_q == STABLE_LAST);
  assign timeout  = (state_q == S_WAIT_LOCK) && (timer_q == TIMEOUT_LAST);
  assign loss_det = in_release_run && !lock_s_q && (filter_q == LOSS_LAST);

  // Process 2: next state plus the counters that follow it.
  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    case (state_q)
      S_RESET_PLL: begin
        if (timer_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (qualify) begin
          state_d = S_RELEASE;
        end else if (timeout) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 4'd1;
            state_d = S_RESET_PLL;
          end else begin
            state_d = S_FAIL;
          end
        end
      end
      S_RELEASE, S_RUN: begin
        if (loss_det) begin
          state_d = S_RESET_PLL;
          loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
        end else if (relock_req) begin
          state_d = S_RESET_PLL;
        end else if (state_q == S_RELEASE && timer_q == RELEASE_LAST) begin
          state_d = S_RUN;
          retry_d = '0;
        end
      end
      S_FAIL: begin
        if (relock_req) begin
          state_d = S_RESET_PLL;
          retry_d = '0;
        end
      end
      default: state_d = S_RESET_PLL;
    endcase

    // Timer saturates and restarts from zero on every state change.
    if (state_d != state_q)  timer_d = '0;
    else if (timer_q == '1)  timer_d = timer_q;
    else                     timer_d = timer_q + CNT_W'(1);

    stable_d = ((state_q == S_WAIT_LOCK) && lock_s_q) ? stable_q + STB_W'(1) : '0;
    filter_d = (in_release_run && !lock_s_q) ? filter_q + LSS_W'(1) : '0;
  end

  // Process 3: registered outputs derived from the upcoming state.
  always_comb begin
    pll_reset_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    locked_d    = (state_d == S_RUN);
    fault_d     = (state_d == S_FAIL);
    stage_d     = '0;
    case (state_d)
      S_RELEASE: begin
        stage_d = stage_q;
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
          if (state_q == S_RELEASE && timer_q == CNT_W'(STAGE_GAP * (i + 1) - 1))
            stage_d[i] = 1'b1;
        end
      end
      S_RUN:   stage_d = '1;
      default: stage_d = '0;
    endcase
  end

  assign pll_reset   = pll_reset_q;
  assign stage_rst_n = stage_q;
  assign locked_ok   = locked_q;
  assign fault       = fault_q;
  assign retry_cnt   = retry_q;
  assign loss_cnt    = loss_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short sim timing parameters.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_pll_reset_sequencer;

  localparam int unsigned NS = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pll_lock;
  logic          relock_req;
  logic          pll_reset;
  logic [NS-1:0] stage_rst_n;
  logic          locked_ok;
  logic          fault;
  logic [3:0]    retry_cnt;
  logic [7:0]    loss_cnt;
  logic [2:0]    state;

  int vectors     = 0;
  int miscompares = 0;
  int n;

  localparam logic [2:0] ST_RESET = 3'd0, ST_WAIT = 3'd1, ST_REL = 3'd2,
                         ST_RUN = 3'd3, ST_FAIL = 3'd4;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(4), .LOCK_STABLE(8), .LOCK_TIMEOUT(40), .LOSS_FILTER(3),
    .STAGE_GAP(5), .NUM_STAGES(NS), .MAX_RETRIES(2), .CNT_W(20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .relock_req (relock_req),
    .pll_reset  (pll_reset),
    .stage_rst_n(stage_rst_n),
    .locked_ok  (locked_ok),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Ticks until state equals target or the budget runs out; returns ticks taken.
  task automatic wait_state(input string tag, input logic [2:0] target, input int budget,
                            output int taken);
    taken = 0;
    while (state !== target && taken < budget) begin
      tick(1);
      taken++;
    end
    check(tag, state, target);
  endtask

  task automatic pulse_relock();
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, state, ST_RESET);
    check({tag, "_pll_reset"}, pll_reset, 1);
    check({tag, "_stage"}, stage_rst_n, 3'b000);
    check({tag, "_locked"}, locked_ok, 0);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_retry"}, retry_cnt, 0);
    check({tag, "_loss"}, loss_cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0; pll_lock = 1'b0; relock_req = 1'b0;
    tick(2);
    check_reset_values("por");
    rst_n = 1'b1;

    // Clean lock: RESET_PLL lasts 4 cycles, lock raised 10 cycles after pll_reset falls.
    wait_state("clean_wait", ST_WAIT, 20, n);
    check("clean_rst_len", n, 4);
    check("clean_pll_reset_low", pll_reset, 0);
    tick(10);
    pll_lock = 1'b1;
    tick(9);
    check("clean_still_wait", state, ST_WAIT);
    tick(1);
    check("clean_release", state, ST_REL);
    check("clean_stage_r0", stage_rst_n, 3'b000);
    tick(4);
    check("clean_stage_r4", stage_rst_n, 3'b000);
    tick(1);
    check("clean_stage_r5", stage_rst_n, 3'b001);
    tick(5);
    check("clean_stage_r10", stage_rst_n, 3'b011);
    tick(4);
    check("clean_state_r14", state, ST_REL);
    check("clean_locked_r14", locked_ok, 0);
    tick(1);
    check("clean_stage_r15", stage_rst_n, 3'b111);
    check("clean_run", state, ST_RUN);
    check("clean_locked", locked_ok, 1);
    check("clean_retry", retry_cnt, 0);
    check("clean_pll_reset", pll_reset, 0);

    // Lock loss: a 2-cycle dropout is filtered, a longer one re-sequences.
    tick(3);
    pll_lock = 1'b0;
    tick(2);
    pll_lock = 1'b1;
    tick(4);
    check("short_drop_state", state, ST_RUN);
    check("short_drop_stage", stage_rst_n, 3'b111);
    check("short_drop_loss", loss_cnt, 0);
    pll_lock = 1'b0;
    tick(4);
    check("loss_pre_state", state, ST_RUN);
    check("loss_pre_stage", stage_rst_n, 3'b111);
    tick(1);
    check("loss_state", state, ST_RESET);
    check("loss_stage", stage_rst_n, 3'b000);
    check("loss_cnt1", loss_cnt, 1);
    check("loss_locked", locked_ok, 0);
    check("loss_pll_reset", pll_reset, 1);
    pll_lock = 1'b1;
    wait_state("reseq_run", ST_RUN, 60, n);
    check("reseq_len", n, 27);
    check("reseq_stage", stage_rst_n, 3'b111);
    check("reseq_loss", loss_cnt, 1);

    // relock_req in RUN, then again after stage 0 released.
    pulse_relock();
    check("relock_run_state", state, ST_RESET);
    check("relock_run_stage", stage_rst_n, 3'b000);
    check("relock_run_locked", locked_ok, 0);
    wait_state("relock_rel", ST_REL, 40, n);
    check("relock_rel_len", n, 12);
    tick(5);
    check("relock_mid_stage0", stage_rst_n, 3'b001);
    pulse_relock();
    check("relock_mid_state", state, ST_RESET);
    check("relock_mid_stage", stage_rst_n, 3'b000);
    check("relock_mid_loss", loss_cnt, 1);
    pll_lock = 1'b0;

    // Glitchy lock: 6 high, 1 low, then high; qualification restarts.
    wait_state("glitch_wait", ST_WAIT, 20, n);
    check("glitch_wait_len", n, 4);
    pll_lock = 1'b1;
    tick(6);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(9);
    check("glitch_still_wait", state, ST_WAIT);
    tick(1);
    check("glitch_release", state, ST_REL);
    check("glitch_retry", retry_cnt, 0);

    // Async reset between edges mid-RELEASE.
    tick(5);
    check("async_pre_stage", stage_rst_n, 3'b001);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    pll_lock = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Timeouts to FAIL with lock held low; relock_req in WAIT_LOCK is ignored.
    wait_state("to1_wait", ST_WAIT, 20, n);
    check("to1_wait_len", n, 4);
    tick(20);
    pulse_relock();
    check("to1_relock_ignored", state, ST_WAIT);
    tick(18);
    check("to1_pre_state", state, ST_WAIT);
    check("to1_pre_retry", retry_cnt, 0);
    tick(1);
    check("to1_state", state, ST_RESET);
    check("to1_retry", retry_cnt, 1);
    check("to1_pll_reset", pll_reset, 1);
    wait_state("to2_wait", ST_WAIT, 20, n);
    check("to2_wait_len", n, 4);
    tick(39);
    check("to2_pre_state", state, ST_WAIT);
    tick(1);
    check("to2_state", state, ST_RESET);
    check("to2_retry", retry_cnt, 2);
    wait_state("to3_wait", ST_WAIT, 20, n);
    tick(39);
    check("to3_pre_state", state, ST_WAIT);
    tick(1);
    check("fail_state", state, ST_FAIL);
    check("fail_fault", fault, 1);
    check("fail_pll_reset", pll_reset, 1);
    check("fail_stage", stage_rst_n, 3'b000);
    check("fail_retry", retry_cnt, 2);
    tick(5);
    check("fail_hold", state, ST_FAIL);
    pulse_relock();
    check("fail_relock_state", state, ST_RESET);
    check("fail_relock_retry", retry_cnt, 0);
    check("fail_relock_fault", fault, 0);

    // loss_cnt saturation: 256 loss events from RUN.
    pll_lock = 1'b1;
    wait_state("sat_run0", ST_RUN, 60, n);
    for (int i = 0; i < 256; i++) begin
      pll_lock = 1'b0;
      tick(5);
      pll_lock = 1'b1;
      wait_state("sat_run", ST_RUN, 60, n);
      if (i == 253) check("sat_loss_254", loss_cnt, 254);
    end
    check("sat_loss_255", loss_cnt, 255);
    check("sat_locked", locked_ok, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
